alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder and performs the operation on two 32-bit operands. Logic and arithmetic ops complete in one cycle. SLL/SRL run on an iterative one-bit-per-cycle shifter, with a ready/valid handshake that stalls the pipeline while a shift is in flight. Results and the zero flag are registered at the EX/MEM boundary.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_shift_seq.sv | 57 +++++
 rtl/alu_exec_unit.sv | 137 +++++++++++++
 tb/tb_alu_exec_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage and the ALU control decoder.
// Contents:
//   - 4-bit operation codes driven by the ALU control decoder
//   - FSM state encoding for alu_exec_unit
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative one-bit-per-cycle shifter used for SLL/SRL.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   flush          - abort: clears the remaining count
//   start          - load start_val/start_cnt/start_left (start_cnt must be > 0)
//   start_left     - 1 = shift left (SLL), 0 = logical shift right (SRL)
//   start_val      - value to shift
//   start_cnt      - number of single-bit steps
//   run            - owning FSM is in its shift state
//   done           - high in the cycle whose step is the last one
//   final_val      - accumulator after this cycle's step (valid with done)
module alu_shift_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               start,
    input  logic               start_left,
    input  logic [WIDTH-1:0]   start_val,
    input  logic [SHAMT_W-1:0] start_cnt,
    input  logic               run,
    output logic               done,
    output logic [WIDTH-1:0]   final_val
);

    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic               left;
    logic [WIDTH-1:0]   stepped;

    always_comb begin
        stepped = left ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
    end

    assign done      = run && (cnt == SHAMT_W'(1));
    assign final_val = stepped;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            cnt  <= '0;
            left <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (start) begin
            acc  <= start_val;
            cnt  <= start_cnt;
            left <= start_left;
        end else if (run && (cnt != '0)) begin
            acc <= stepped;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Single-cycle logic/arithmetic ops; SLL/SRL run on an
// iterative shifter and stall acceptance while in flight. Result and zero
// flag are registered at the EX/MEM boundary.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   in_valid     - operation presented this cycle
//   in_ready     - unit can accept (low while shifting or in reset)
//   alu_ctrl     - 4-bit op code from the ALU control decoder
//   operand_a    - rs value
//   operand_b    - rt value / immediate; shift source
//   shamt        - shift amount for SLL/SRL
//   flush        - synchronous abort from the hazard unit
//   out_valid    - one-cycle pulse when result/zero update
//   result       - registered result, held between pulses
//   zero         - registered (result == 0)
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero
);

    alu_state_t         state, state_next;
    logic [WIDTH-1:0]   op_res;
    logic               is_shift;
    logic               accept;
    logic               sh_start;
    logic               sh_done;
    logic [WIDTH-1:0]   sh_final;
    logic               load;
    logic [WIDTH-1:0]   load_val;

    // Single-cycle datapath. Shift codes yield operand_b, which is the
    // correct answer for shamt == 0; nonzero shifts go through alu_shift_seq.
    always_comb begin
        op_res   = operand_a + operand_b;
        is_shift = 1'b0;
        case (alu_ctrl)
            ALU_AND: op_res = operand_a & operand_b;
            ALU_OR:  op_res = operand_a | operand_b;
            ALU_ADD: op_res = operand_a + operand_b;
            ALU_SUB: op_res = operand_a - operand_b;
            ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            ALU_NOR: op_res = ~(operand_a | operand_b);
            ALU_SLL, ALU_SRL: begin
                op_res   = operand_b;
                is_shift = 1'b1;
            end
            default: op_res = operand_a + operand_b;
        endcase
    end

    assign in_ready = (state == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        sh_start   = 1'b0;
        load       = 1'b0;
        load_val   = op_res;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        sh_start   = 1'b1;
                        state_next = ST_SHIFT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    load       = 1'b1;
                    load_val   = sh_final;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Flush overrides both a fresh accept and a completing shift.
        if (flush) begin
            state_next = ST_IDLE;
            sh_start   = 1'b0;
            load       = 1'b0;
        end
    end

    alu_shift_seq #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .start      (sh_start),
        .start_left (alu_ctrl == ALU_SLL),
        .start_val  (operand_b),
        .start_cnt  (shamt),
        .run        (state == ST_SHIFT),
        .done       (sh_done),
        .final_val  (sh_final)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= load;
            if (load) begin
                result <= load_val;
                zero   <= (load_val == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  shamt;
    logic        flush;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .shamt     (shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        in_valid  = 1'b1;
        alu_ctrl  = c;
        operand_a = a;
        operand_b = b;
        shamt     = s;
    endtask

    initial begin
        int n;
        vecs[0]  = '{4'b0010, 32'd5,        32'd7,        5'd0, 32'd12,       1'b0};
        vecs[1]  = '{4'b0110, 32'd9,        32'd9,        5'd0, 32'd0,        1'b1};
        vecs[2]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd1,        1'b0};
        vecs[3]  = '{4'b0111, 32'h7FFFFFFF, 32'h80000000, 5'd0, 32'd0,        1'b1};
        vecs[4]  = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 5'd0, 32'd1,        1'b0};
        vecs[5]  = '{4'b0101, 32'd3,        32'd4,        5'd0, 32'd7,        1'b0};
        vecs[6]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0};
        vecs[7]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1'b0};
        vecs[8]  = '{4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h000F000F, 1'b0};
        vecs[9]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,        1'b1};
        vecs[10] = '{4'b0110, 32'd0,        32'd1,        5'd0, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{4'b1000, 32'h12345678, 32'hA5,       5'd0, 32'hA5,       1'b0};
        vecs[12] = '{4'b1001, 32'h0,        32'h80000001, 5'd0, 32'h80000001, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        alu_ctrl = '0; operand_a = '0; operand_b = '0; shamt = '0;
        step(); step();
        chk("reset_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_ov",    {31'd0, out_valid}, 32'd0);
        chk("reset_res",   result, 32'd0);
        chk("reset_zero",  {31'd0, zero}, 32'd1);
        reset = 1'b0;
        step();
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back single-cycle ops, one accept per cycle.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh);
            step();
            chk($sformatf("vec%0d_ov", i),   {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_res", i),  result, vecs[i].exp_res);
            chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
        end
        in_valid = 1'b0;
        step();
        chk("hold_ov",  {31'd0, out_valid}, 32'd0);
        chk("hold_res", result, 32'h80000001);

        // SLL shamt=4 with in_valid held for a following ADD.
        drive(4'b1000, 32'hDEAD, 32'h1, 5'd4);
        step();
        drive(4'b0010, 32'd1, 32'd2, 5'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sll4_ready%0d", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("sll4_ov%0d", k),    {31'd0, out_valid}, 32'd0);
            step();
        end
        chk("sll4_ov",    {31'd0, out_valid}, 32'd1);
        chk("sll4_res",   result, 32'h10);
        chk("sll4_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("after_sll_ov",  {31'd0, out_valid}, 32'd1);
        chk("after_sll_res", result, 32'd3);

        // SRL shamt=31: latency 32.
        drive(4'b1001, 32'h0, 32'h80000000, 5'd31);
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk("srl31_lat",  n, 32);
        chk("srl31_res",  result, 32'h1);
        chk("srl31_zero", {31'd0, zero}, 32'd0);
        step();

        // Flush during the 2nd shift cycle of SLL shamt=8.
        drive(4'b1000, 32'h0, 32'h3, 5'd8);
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_ov",    {31'd0, out_valid}, 32'd0);
        chk("flush_res",   result, 32'h1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid) n++;
        end
        chk("flush_no_ov", n, 0);

        // Flush together with an accept drops the op.
        drive(4'b0010, 32'd40, 32'd2, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_acc_ov",  {31'd0, out_valid}, 32'd0);
        step();
        chk("flush_acc_ov2", {31'd0, out_valid}, 32'd0);
        chk("flush_acc_res", result, 32'h1);

        // Reset mid-shift.
        drive(4'b1000, 32'h0, 32'h5, 5'd8);
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_ready_comb", {31'd0, in_ready}, 32'd0);
        step();
        chk("rst_mid_res",  result, 32'd0);
        chk("rst_mid_zero", {31'd0, zero}, 32'd1);
        chk("rst_mid_ov",   {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        step();
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid) n++;
        end
        chk("rst_mid_no_ov", n, 0);

        // SRL shamt=1, shortest iterative shift.
        drive(4'b1001, 32'h0, 32'hF0, 5'd1);
        step();
        in_valid = 1'b0;
        chk("srl1_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("srl1_ov",  {31'd0, out_valid}, 32'd1);
        chk("srl1_res", result, 32'h78);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
